pc_sequencer: RTL and testbench

Multi-cycle program-counter sequencer for the mini processor. It owns the PC register and runs the fetch/decode handshake with instruction memory. It resolves the 2-bit next-PC source (sequential, conditional branch, jump, register jump) against the ALU zero flag. It drives the resolved 4-way next-PC select and exposes it for trace.

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 55 +++++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: datapath width, next-PC source encoding and FSM states.
// Optional feature macro used by the design files: BRANCH_NE_EN (adds the bne qualifier).
package pc_seq_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_JR  = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_DECODE
  } state_e;

  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC resolution: branch decision, resolved 4-way select and word-aligned next PC.
// With BRANCH_NE_EN defined, the bne input inverts the sense of the zero flag for conditional branches.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_STEP = 32'd4
) (
  input  logic [1:0]      pc_src,
  input  logic            zero,
`ifdef BRANCH_NE_EN
  input  logic            bne,
`endif
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] reg_target,
  output logic [1:0]      mux_sel,
  output logic [PC_W-1:0] next_pc,
  output logic            target_misalign
);

  logic            taken;
  logic [PC_W-1:0] raw_pc;

  always_comb begin
`ifdef BRANCH_NE_EN
    taken = bne ? ~zero : zero;
`else
    taken = zero;
`endif
    mux_sel = PC_SEQ;
    raw_pc  = pc + PC_STEP;
    case (pc_src)
      PC_BR: begin
        if (taken) begin
          mux_sel = PC_BR;
          raw_pc  = branch_target;
        end
      end
      PC_JMP: begin
        mux_sel = PC_JMP;
        raw_pc  = jump_target;
      end
      PC_JR: begin
        mux_sel = PC_JR;
        raw_pc  = reg_target;
      end
      default: ;
    endcase
    // Only non-sequential targets can report misalignment; the loaded PC is always word aligned.
    next_pc         = align_word(raw_pc);
    target_misalign = (mux_sel != PC_SEQ) && (raw_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetch/decode handshake FSM, PC register, retired counter and redirect/misalign pulses.
// Define BRANCH_NE_EN to add the bne port for branch-on-not-equal.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [PC_W-1:0] pc,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic [1:0]      pc_src,
  input  logic            zero,
`ifdef BRANCH_NE_EN
  input  logic            bne,
`endif
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] reg_target,
  output logic [1:0]      mux_sel,
  output logic            redirect,
  output logic            misalign,
  output logic [PC_W-1:0] retired_cnt
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] cnt_q, cnt_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic            accept;
  logic [1:0]      sel_raw;
  logic [PC_W-1:0] next_pc;
  logic            target_misalign;

  pc_next_sel #(
    .PC_STEP(PC_STEP)
  ) u_next_sel (
    .pc_src         (pc_src),
    .zero           (zero),
`ifdef BRANCH_NE_EN
    .bne            (bne),
`endif
    .pc             (pc_q),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .reg_target     (reg_target),
    .mux_sel        (sel_raw),
    .next_pc        (next_pc),
    .target_misalign(target_misalign)
  );

  always_comb begin
    accept     = (state_q == S_DECODE) && instr_valid && !stall;
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (fetch_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (accept) begin
          state_d    = S_FETCH;
          pc_d       = next_pc;
          cnt_d      = cnt_q + PC_W'(1);
          redirect_d = (sel_raw != PC_SEQ);
          misalign_d = target_misalign;
        end
      end
      default:  state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  // The select is only meaningful while an instruction is being decoded.
  assign mux_sel     = (state_q == S_DECODE) ? sel_raw : PC_SEQ;
  assign fetch_valid = (state_q == S_FETCH);
  assign pc          = pc_q;
  assign retired_cnt = cnt_q;
  assign redirect    = redirect_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus predicts each retired instruction into a queue,
// a negedge monitor pops and compares whenever a new fetch is presented after an accept.
module tb_pc_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] cnt;
      logic        redirect;
      logic        misalign;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] pc;
   logic        instr_valid;
   logic        stall;
   logic [1:0]  pc_src;
   logic        zero;
`ifdef BRANCH_NE_EN
   logic        bne;
`endif
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] reg_target;
   logic [1:0]  mux_sel;
   logic        redirect;
   logic        misalign;
   logic [31:0] retired_cnt;

   int          vectors = 0;
   int          miscompares = 0;
   exp_t        exp_q[$];
   logic [31:0] model_pc;
   logic [31:0] model_cnt;
   logic        prev_fv = 1'b0;

   pc_sequencer #(
      .RESET_PC(RESET_PC),
      .PC_STEP (32'd4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_valid  (fetch_valid),
      .fetch_ready  (fetch_ready),
      .pc           (pc),
      .instr_valid  (instr_valid),
      .stall        (stall),
      .pc_src       (pc_src),
      .zero         (zero),
`ifdef BRANCH_NE_EN
      .bne          (bne),
`endif
      .branch_target(branch_target),
      .jump_target  (jump_target),
      .reg_target   (reg_target),
      .mux_sel      (mux_sel),
      .redirect     (redirect),
      .misalign     (misalign),
      .retired_cnt  (retired_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so a stuck DUT can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Branch decision straight from the instruction-set rules.
   function automatic logic expTaken(input logic z);
`ifdef BRANCH_NE_EN
      return bne ? !z : z;
`else
      return z;
`endif
   endfunction

   // Reference state after reset, plus the record the first post-reset fetch must show.
   task automatic resetModel();
      exp_t e;
      model_pc  = RESET_PC;
      model_cnt = 32'd0;
      exp_q.delete();
      e.pc = RESET_PC;
      e.cnt = 32'd0;
      e.redirect = 1'b0;
      e.misalign = 1'b0;
      exp_q.push_back(e);
   endtask

   // Wait for fetch_valid, hold off fetch_ready for a while, then complete the fetch handshake.
   task automatic fetchPhase(input int fetch_wait, output bit ok);
      int guard;
      guard = 0;
      ok = 1'b1;
      fetch_ready = 1'b0;
      instr_valid = 1'b1;
      stall = 1'b0;
      pc_src = 2'($urandom_range(0, 3));
      while (!fetch_valid && guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!fetch_valid) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL fetch_timeout: fetch_valid still 0 after %0d cycles, expected 1", guard);
         ok = 1'b0;
         return;
      end
      for (int i = 0; i < fetch_wait; i++) begin
         @(posedge clk); #1;
         checkOutput("fetch_hold_valid", 32'(fetch_valid), 32'd1);
         checkOutput("fetch_hold_pc", pc, model_pc);
      end
      fetch_ready = 1'b1;
      @(posedge clk); #1;
      fetch_ready = 1'($urandom_range(0, 1));
      instr_valid = 1'b0;
   endtask

   // One complete instruction: fetch, optional stall/idle cycles in decode, then accept.
   task automatic applyStimulus(input logic [1:0] src, input logic z, input logic [31:0] bt,
                                input logic [31:0] jt, input logic [31:0] rt,
                                input int fetch_wait, input int hold_cyc, input bit rand_hold);
      bit          ok;
      exp_t        e;
      logic [1:0]  exp_sel;
      logic [31:0] target;
      fetchPhase(fetch_wait, ok);
      if (!ok) return;
      pc_src = src;
      zero = z;
      branch_target = bt;
      jump_target = jt;
      reg_target = rt;

      exp_sel = src;
      if (src == 2'd1 && !expTaken(z)) exp_sel = 2'd0;
      case (exp_sel)
         2'd1:    target = bt;
         2'd2:    target = jt;
         2'd3:    target = rt;
         default: target = model_pc + 32'd4;
      endcase

      for (int i = 0; i < hold_cyc; i++) begin
         if (rand_hold && $urandom_range(0, 3) == 0) begin
            stall = 1'b0;
            instr_valid = 1'b0;
         end else begin
            stall = 1'b1;
            instr_valid = rand_hold ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         #1;
         checkOutput("decode_mux_sel", 32'(mux_sel), 32'(exp_sel));
         @(posedge clk); #1;
         checkOutput("hold_pc", pc, model_pc);
         checkOutput("hold_retired_cnt", retired_cnt, model_cnt);
         checkOutput("hold_fetch_valid", 32'(fetch_valid), 32'd0);
         checkOutput("hold_redirect", 32'(redirect), 32'd0);
      end

      stall = 1'b0;
      instr_valid = 1'b1;
      #1;
      checkOutput("decode_mux_sel", 32'(mux_sel), 32'(exp_sel));

      e.redirect = (exp_sel != 2'd0);
      e.misalign = (exp_sel != 2'd0) && (target % 4 != 0);
      e.pc = target - (target % 4);
      e.cnt = model_cnt + 32'd1;
      model_pc = e.pc;
      model_cnt = e.cnt;
      exp_q.push_back(e);

      @(posedge clk); #1;
      instr_valid = 1'b0;
      fetch_ready = 1'b0;
      pc_src = 2'($urandom_range(0, 3));
      zero = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      jump_target = $urandom;
      reg_target = $urandom;
   endtask

   // Monitor: a fresh fetch after an accept carries the new pc, count and the one-cycle pulses.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_fv = 1'b0;
      end else begin
         if (fetch_valid && !prev_fv) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_fetch: pc %h presented with no pending expectation", pc);
            end else begin
               e = exp_q.pop_front();
               checkOutput("sb_pc", pc, e.pc);
               checkOutput("sb_retired_cnt", retired_cnt, e.cnt);
               checkOutput("sb_redirect", 32'(redirect), 32'(e.redirect));
               checkOutput("sb_misalign", 32'(misalign), 32'(e.misalign));
            end
         end else if (fetch_valid) begin
            checkOutput("pulse_redirect_cleared", 32'(redirect), 32'd0);
            checkOutput("pulse_misalign_cleared", 32'(misalign), 32'd0);
         end
         if (fetch_valid) checkOutput("fetch_mux_sel", 32'(mux_sel), 32'd0);
         prev_fv = fetch_valid;
      end
   end

   // Main stimulus sequence: directed cases first, then randomized instructions.
   initial begin
      bit ok;
      rst = 1'b1;
      fetch_ready = 1'b0;
      instr_valid = 1'b0;
      stall = 1'b0;
      pc_src = 2'd0;
      zero = 1'b0;
`ifdef BRANCH_NE_EN
      bne = 1'b0;
`endif
      branch_target = 32'd0;
      jump_target = 32'd0;
      reg_target = 32'd0;
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_pc", pc, RESET_PC);
      checkOutput("reset_fetch_valid", 32'(fetch_valid), 32'd0);
      checkOutput("reset_retired_cnt", retired_cnt, 32'd0);
      checkOutput("reset_mux_sel", 32'(mux_sel), 32'd0);
      checkOutput("reset_redirect", 32'(redirect), 32'd0);
      checkOutput("reset_misalign", 32'(misalign), 32'd0);

      fetch_ready = 1'b1;
      rst = 1'b0;
      #1;
      checkOutput("release_fetch_valid_low", 32'(fetch_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("first_fetch_valid", 32'(fetch_valid), 32'd1);
      checkOutput("first_fetch_pc", pc, RESET_PC);

      // Sequential wrap across the top of the address space.
      applyStimulus(2'd2, 1'b0, 32'd0, 32'hFFFF_FFF8, 32'd0, 0, 0, 1'b0);
      repeat (3) applyStimulus(2'd0, 1'b0, 32'h1234_0000, 32'h5678_0000, 32'h9ABC_0000, 0, 0, 1'b0);

      // Conditional branch, taken then not taken.
      applyStimulus(2'd1, 1'b1, 32'h0000_0040, 32'd0, 32'd0, 1, 0, 1'b0);
      applyStimulus(2'd1, 1'b0, 32'h0000_0040, 32'd0, 32'd0, 0, 1, 1'b0);

      // Stall beats instr_valid for five cycles, then a misaligned register jump.
      applyStimulus(2'd3, 1'b0, 32'd0, 32'd0, 32'h0000_0203, 2, 5, 1'b0);

`ifdef BRANCH_NE_EN
      bne = 1'b1;
      applyStimulus(2'd1, 1'b0, 32'h0000_0080, 32'd0, 32'd0, 0, 0, 1'b0);
      applyStimulus(2'd1, 1'b1, 32'h0000_0080, 32'd0, 32'd0, 0, 0, 1'b0);
      bne = 1'b0;
`endif

      // Asynchronous reset while an instruction sits in decode.
      fetchPhase(0, ok);
      if (ok) begin
         pc_src = 2'd2;
         jump_target = 32'h0000_0F00;
         #2;
         rst = 1'b1;
         resetModel();
         #1;
         checkOutput("async_pc", pc, RESET_PC);
         checkOutput("async_fetch_valid", 32'(fetch_valid), 32'd0);
         checkOutput("async_retired_cnt", retired_cnt, 32'd0);
         checkOutput("async_mux_sel", 32'(mux_sel), 32'd0);
         @(posedge clk); #1;
         rst = 1'b0;
         @(posedge clk); #1;
         checkOutput("post_reset_fetch_valid", 32'(fetch_valid), 32'd1);
      end

      // Randomized instruction stream with mixed alignment and handshake delays.
      for (int n = 0; n < 150; n++) begin
         logic [31:0] bt, jt, rt;
         bt = $urandom;
         jt = $urandom;
         rt = $urandom;
         if ($urandom_range(0, 1) == 1) bt[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1) jt[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1) rt[1:0] = 2'b00;
`ifdef BRANCH_NE_EN
         bne = 1'($urandom_range(0, 1));
`endif
         applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), bt, jt, rt,
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1);
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
